// File: rtl/sp_ram_test_master_if.sv
// rtl/sp_ram_test_master_if.sv - single-port RAM access bundle between test master and RAM
interface sp_ram_test_master_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32
);
  logic                    ram_en_o;
  logic                    ram_we_o;
  logic [ADDR_WIDTH-1:0]   ram_addr_o;
  logic [DATA_WIDTH-1:0]   ram_wdata_o;
  logic [DATA_WIDTH/8-1:0] ram_be_o;
  logic                    ram_bypass_en_o;
  logic [DATA_WIDTH-1:0]   ram_rdata_i;

  // Test master drives the request side and consumes read data.
  modport master (
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o, ram_bypass_en_o,
    input  ram_rdata_i
  );

  // RAM receives requests and returns read data one cycle later.
  modport slave (
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o, ram_bypass_en_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/sp_ram_test_master.sv
// rtl/sp_ram_test_master.sv - fill / check / fill-then-check pattern engine for a single-port RAM
module sp_ram_test_master #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [DATA_WIDTH-1:0] pattern_i,
  input  logic                  incr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [LEN_WIDTH-1:0]  err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  sp_ram_test_master_if.master  ram
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                state;
  logic                  fill_check_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [DATA_WIDTH-1:0] pat_q;
  logic                  incr_q;
  logic [LEN_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0] cur_val;

  // Registered RAM request outputs.
  logic                  ram_en_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic [BE_WIDTH-1:0]   ram_be_q;

  // One-stage compare pipeline: expected value and address of the read issued last cycle.
  logic                  cmp_valid;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic [ADDR_WIDTH-1:0] cmp_addr;

  logic                  last_word;
  logic [DATA_WIDTH-1:0] next_val;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  unused_ok;

  assign last_word  = (idx == len_q - 1'b1);
  assign next_val   = incr_q ? cur_val + 1'b1 : cur_val;
  assign next_addr  = ram_addr_q + ADDR_WIDTH'(4);
  assign start_addr = {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign unused_ok  = &{1'b0, base_addr_i[1:0]};

  assign ram.ram_en_o        = ram_en_q;
  assign ram.ram_we_o        = ram_we_q;
  assign ram.ram_addr_o      = ram_addr_q;
  assign ram.ram_wdata_o     = ram_wdata_q;
  assign ram.ram_be_o        = ram_be_q;
  assign ram.ram_bypass_en_o = 1'b0;

  // Command sequencer, RAM request generation and read-data compare.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state            <= IDLE;
      fill_check_q     <= 1'b0;
      base_q           <= '0;
      len_q            <= '0;
      pat_q            <= '0;
      incr_q           <= 1'b0;
      idx              <= '0;
      cur_val          <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
      ram_en_q         <= 1'b0;
      ram_we_q         <= 1'b0;
      ram_addr_q       <= '0;
      ram_wdata_q      <= '0;
      ram_be_q         <= '0;
      cmp_valid        <= 1'b0;
      cmp_exp          <= '0;
      cmp_addr         <= '0;
    end else begin
      done_o    <= 1'b0;
      cmp_valid <= 1'b0;

      if (cmp_valid && (ram.ram_rdata_i != cmp_exp)) begin
        err_o <= 1'b1;
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
        if (err_cnt_o == '0) first_err_addr_o <= cmp_addr;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            fill_check_q     <= (mode_i == 2'b10);
            base_q           <= start_addr;
            len_q            <= len_i;
            pat_q            <= pattern_i;
            incr_q           <= incr_i;
            idx              <= '0;
            cur_val          <= pattern_i;
            err_o            <= 1'b0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            ram_addr_q       <= start_addr;
            if (len_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else if (!mode_i[0]) begin
              state       <= WRITE;
              busy_o      <= 1'b1;
              ram_en_q    <= 1'b1;
              ram_we_q    <= 1'b1;
              ram_be_q    <= '1;
              ram_wdata_q <= pattern_i;
            end else begin
              state    <= READ;
              busy_o   <= 1'b1;
              ram_en_q <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (last_word) begin
            ram_we_q    <= 1'b0;
            ram_be_q    <= '0;
            ram_wdata_q <= '0;
            if (fill_check_q) begin
              state      <= READ;
              idx        <= '0;
              cur_val    <= pat_q;
              ram_addr_q <= base_q;
            end else begin
              state    <= DONE;
              done_o   <= 1'b1;
              busy_o   <= 1'b0;
              ram_en_q <= 1'b0;
            end
          end else begin
            idx         <= idx + 1'b1;
            cur_val     <= next_val;
            ram_wdata_q <= next_val;
            ram_addr_q  <= next_addr;
          end
        end

        READ: begin
          cmp_valid <= 1'b1;
          cmp_exp   <= cur_val;
          cmp_addr  <= ram_addr_q;
          if (last_word) begin
            state    <= DRAIN;
            ram_en_q <= 1'b0;
          end else begin
            idx        <= idx + 1'b1;
            cur_val    <= next_val;
            ram_addr_q <= next_addr;
          end
        end

        DRAIN: begin
          state  <= DONE;
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ram_test_master.sv
// tb/tb_sp_ram_test_master.sv - directed self-checking bench for sp_ram_test_master
module tb_sp_ram_test_master;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic [DW-1:0] pat;
  logic          incr;
  logic          busy, done, err;
  logic [LW-1:0] err_cnt;
  logic [AW-1:0] first_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sp_ram_test_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_if ();

  sp_ram_test_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk              (clk),
    .rst_i            (rst),
    .start_i          (start),
    .mode_i           (mode),
    .base_addr_i      (base),
    .len_i            (len),
    .pattern_i        (pat),
    .incr_i           (incr),
    .busy_o           (busy),
    .done_o           (done),
    .err_o            (err),
    .err_cnt_o        (err_cnt),
    .first_err_addr_o (first_err),
    .ram              (ram_if)
  );

  // Behavioural RAM with optional single-word read corruption.
  logic [DW-1:0] mem [0:65535];
  logic          corrupt_en = 1'b0;
  logic [15:0]   corrupt_idx = 16'h0;

  always @(posedge clk) begin
    if (ram_if.ram_en_o) begin
      if (ram_if.ram_we_o)
        mem[ram_if.ram_addr_o[17:2]] <= ram_if.ram_wdata_o;
      else if (corrupt_en && ram_if.ram_addr_o[17:2] == corrupt_idx)
        ram_if.ram_rdata_i <= mem[ram_if.ram_addr_o[17:2]] ^ 32'h0000_0001;
      else
        ram_if.ram_rdata_i <= mem[ram_if.ram_addr_o[17:2]];
    end
  end

  logic [AW-1:0] la  [0:63];
  logic          lwe [0:63];
  logic [DW-1:0] ld  [0:63];
  logic [3:0]    lbe [0:63];
  int            nacc;
  int            done_cyc;
  logic          busy1, busyd;
  logic          saw_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] m, input logic [AW-1:0] b, input logic [LW-1:0] l,
                         input logic [DW-1:0] p, input logic inc, input logic pulse);
    @(negedge clk);
    start = 1'b1; mode = m; base = b; len = l; pat = p; incr = inc;
    nacc = 0; done_cyc = -1; busy1 = 1'b0; busyd = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin busy1 = busy; start = 1'b0; end
      if (pulse && c == 2) begin start = 1'b1; mode = 2'b01; base = '0; len = 16'd1; end
      if (pulse && c == 3) start = 1'b0;
      if (ram_if.ram_en_o && nacc < 64) begin
        la[nacc]  = ram_if.ram_addr_o;
        lwe[nacc] = ram_if.ram_we_o;
        ld[nacc]  = ram_if.ram_wdata_o;
        lbe[nacc] = ram_if.ram_be_o;
        nacc++;
      end
      if (done) begin done_cyc = c; busyd = busy; break; end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; base = '0; len = '0; pat = '0; incr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_errcnt", err_cnt, 16'h0);
    chk("rst_first", first_err, 18'h0);
    chk("rst_en", ram_if.ram_en_o, 1'b0);
    chk("rst_we", ram_if.ram_we_o, 1'b0);
    chk("rst_addr", ram_if.ram_addr_o, 18'h0);
    chk("rst_wdata", ram_if.ram_wdata_o, 32'h0);
    chk("rst_be", ram_if.ram_be_o, 4'h0);
    chk("rst_bypass", ram_if.ram_bypass_en_o, 1'b0);
    rst = 1'b0;

    // Fill, incrementing pattern.
    run_cmd(2'b00, 18'h00100, 16'd4, 32'hA5A5_0000, 1'b1, 1'b0);
    chk("fill_done_cyc", done_cyc, 5);
    chk("fill_nacc", nacc, 4);
    chk("fill_busy1", busy1, 1'b1);
    chk("fill_busy_done", busyd, 1'b0);
    chk("fill_addr0", la[0], 18'h00100);
    chk("fill_addr3", la[3], 18'h0010C);
    chk("fill_data0", ld[0], 32'hA5A5_0000);
    chk("fill_data3", ld[3], 32'hA5A5_0003);
    chk("fill_we3", lwe[3], 1'b1);
    chk("fill_be1", lbe[1], 4'hF);

    // Fill-then-check, data wraps past all-ones.
    run_cmd(2'b10, 18'h00200, 16'd8, 32'hFFFF_FFFE, 1'b1, 1'b0);
    chk("ftc_done_cyc", done_cyc, 18);
    chk("ftc_nacc", nacc, 16);
    chk("ftc_data2", ld[2], 32'h0000_0000);
    chk("ftc_rd_addr", la[8], 18'h00200);
    chk("ftc_rd_we", lwe[8], 1'b0);
    chk("ftc_rd_wdata", ld[8], 32'h0);
    chk("ftc_err", err, 1'b0);
    chk("ftc_errcnt", err_cnt, 16'h0);

    // Check with one corrupted word.
    corrupt_en = 1'b1; corrupt_idx = 16'h0042;
    run_cmd(2'b01, 18'h00100, 16'd4, 32'hA5A5_0000, 1'b1, 1'b0);
    chk("chk_done_cyc", done_cyc, 6);
    chk("chk_err", err, 1'b1);
    chk("chk_errcnt", err_cnt, 16'd1);
    chk("chk_first", first_err, 18'h00108);
    repeat (3) @(negedge clk);
    chk("chk_err_held", err, 1'b1);
    chk("chk_first_held", first_err, 18'h00108);

    // Every word wrong: count all, keep the first address.
    run_cmd(2'b01, 18'h00100, 16'd4, 32'h0, 1'b0, 1'b0);
    chk("all_errcnt", err_cnt, 16'd4);
    chk("all_first", first_err, 18'h00100);
    corrupt_en = 1'b0;

    // Address wrap, low base bits ignored.
    run_cmd(2'b00, 18'h3FFFB, 16'd4, 32'h0000_0007, 1'b0, 1'b0);
    chk("wrap_addr0", la[0], 18'h3FFF8);
    chk("wrap_addr1", la[1], 18'h3FFFC);
    chk("wrap_addr2", la[2], 18'h00000);
    chk("wrap_addr3", la[3], 18'h00004);
    chk("wrap_err_cleared", err, 1'b0);
    run_cmd(2'b11, 18'h3FFF8, 16'd4, 32'h0000_0007, 1'b0, 1'b0);
    chk("mode3_done_cyc", done_cyc, 6);
    chk("mode3_err", err, 1'b0);

    // Zero-length command.
    run_cmd(2'b10, 18'h00100, 16'd0, 32'h1, 1'b0, 1'b0);
    chk("len0_done_cyc", done_cyc, 1);
    chk("len0_nacc", nacc, 0);

    // Start pulsed while busy is ignored.
    run_cmd(2'b00, 18'h00400, 16'd4, 32'h0000_1000, 1'b1, 1'b1);
    chk("busy_start_done_cyc", done_cyc, 5);
    chk("busy_start_nacc", nacc, 4);
    chk("busy_start_addr3", la[3], 18'h0040C);
    chk("busy_start_data3", ld[3], 32'h0000_1003);

    // Reset in the middle of a READ phase, with a mismatch compare pending.
    corrupt_en = 1'b1; corrupt_idx = 16'h0042;
    @(negedge clk);
    start = 1'b1; mode = 2'b01; base = 18'h00100; len = 16'd4; pat = 32'hA5A5_0000; incr = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_err", err, 1'b0);
    chk("mrst_errcnt", err_cnt, 16'h0);
    chk("mrst_en", ram_if.ram_en_o, 1'b0);
    chk("mrst_addr", ram_if.ram_addr_o, 18'h0);
    rst = 1'b0;
    corrupt_en = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    chk("mrst_no_done", saw_done, 1'b0);
    chk("mrst_no_err", err, 1'b0);
    run_cmd(2'b10, 18'h00800, 16'd3, 32'h0000_0055, 1'b0, 1'b0);
    chk("post_rst_done_cyc", done_cyc, 8);
    chk("post_rst_nacc", nacc, 6);
    chk("post_rst_err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
